// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control, FTZ and flags.
// Define FP_MULT_PIPE_RNE_EN for round-to-nearest-even; the default build truncates toward zero.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [3:0]           out_flags
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned PW   = 2 * (MAN_W + 1);
    localparam int unsigned XW   = EXP_W + 2;
    localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);

    // Whole pipe moves as one; a stalled output freezes every stage.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: unpack, classify, multiply significands, add exponents.
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_c;
    logic [PW-1:0]    prod_c;
    logic signed [XW-1:0] exp_sum_c;

    assign {sa, ea, ma} = in_a;
    assign {sb, eb, mb} = in_b;
    assign zero_a    = (ea == '0);
    assign zero_b    = (eb == '0);
    assign inf_a     = (ea == '1) && (ma == '0);
    assign inf_b     = (eb == '1) && (mb == '0);
    assign nan_a     = (ea == '1) && (ma != '0);
    assign nan_b     = (eb == '1) && (mb != '0);
    assign snan_c    = (nan_a && !ma[MAN_W-1]) || (nan_b && !mb[MAN_W-1]);
    assign prod_c    = PW'({1'b1, ma}) * PW'({1'b1, mb});
    assign exp_sum_c = $signed(XW'(ea)) + $signed(XW'(eb)) - $signed(XW'(BIAS));

    logic                 v1, s1, nan1, snan1, inf1, zero1;
    logic [PW-1:0]        prod1;
    logic signed [XW-1:0] exp1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v1    <= 1'b0;
            s1    <= 1'b0;
            nan1  <= 1'b0;
            snan1 <= 1'b0;
            inf1  <= 1'b0;
            zero1 <= 1'b0;
            prod1 <= '0;
            exp1  <= '0;
        end else if (advance) begin
            v1    <= in_valid;
            s1    <= sa ^ sb;
            nan1  <= nan_a || nan_b;
            snan1 <= snan_c;
            inf1  <= inf_a || inf_b;
            zero1 <= zero_a || zero_b;
            prod1 <= prod_c;
            exp1  <= exp_sum_c;
        end
    end

    // Stage 2: normalise so the hidden bit drops off the top, then round.
    logic [PW-2:0]        norm_c;
    logic [MAN_W-1:0]     mant_n_c, mant_r_c;
    logic                 guard_c, sticky_c;
    logic signed [XW-1:0] exp_n_c, exp_r_c;

    always_comb begin
        norm_c   = prod1[PW-1] ? prod1[PW-2:0] : {prod1[PW-3:0], 1'b0};
        exp_n_c  = prod1[PW-1] ? exp1 + EXP_ONE : exp1;
        mant_n_c = norm_c[PW-2 -: MAN_W];
        guard_c  = norm_c[PW-2-MAN_W];
        sticky_c = |norm_c[PW-3-MAN_W:0];
    end

`ifdef FP_MULT_PIPE_RNE_EN
    logic             round_up_c;
    logic [MAN_W:0]   mant_sum_c;

    // A carry out leaves the mantissa field all-zero, so only the exponent needs bumping.
    always_comb begin
        round_up_c = guard_c && (sticky_c || mant_n_c[0]);
        mant_sum_c = {1'b0, mant_n_c} + (MAN_W + 1)'(round_up_c);
        mant_r_c   = mant_sum_c[MAN_W-1:0];
        exp_r_c    = mant_sum_c[MAN_W] ? exp_n_c + EXP_ONE : exp_n_c;
    end
`else
    always_comb begin
        mant_r_c = mant_n_c;
        exp_r_c  = exp_n_c;
    end
`endif

    logic                 v2, s2, nan2, snan2, inf2, zero2, inexact2;
    logic [MAN_W-1:0]     mant2;
    logic signed [XW-1:0] exp2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v2       <= 1'b0;
            s2       <= 1'b0;
            nan2     <= 1'b0;
            snan2    <= 1'b0;
            inf2     <= 1'b0;
            zero2    <= 1'b0;
            inexact2 <= 1'b0;
            mant2    <= '0;
            exp2     <= '0;
        end else if (advance) begin
            v2       <= v1;
            s2       <= s1;
            nan2     <= nan1;
            snan2    <= snan1;
            inf2     <= inf1;
            zero2    <= zero1;
            inexact2 <= guard_c || sticky_c;
            mant2    <= mant_r_c;
            exp2     <= exp_r_c;
        end
    end

    // Stage 3: special operands first, then range checks on the rounded exponent.
    logic [W-1:0] res_c;
    logic [3:0]   flags_c;

    always_comb begin
        res_c   = '0;
        flags_c = 4'b0000;
        if (nan2 || (inf2 && zero2)) begin
            res_c      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_c[3] = snan2 || (inf2 && zero2);
        end else if (inf2) begin
            res_c = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (zero2) begin
            res_c = {s2, {(EXP_W+MAN_W){1'b0}}};
        end else if (exp2 >= EXP_MAX) begin
`ifdef FP_MULT_PIPE_RNE_EN
            res_c   = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            res_c   = {s2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
            flags_c = 4'b0101;
        end else if (exp2 <= EXP_ZERO) begin
            res_c   = {s2, {(EXP_W+MAN_W){1'b0}}};
            flags_c = 4'b0011;
        end else begin
            res_c   = {s2, exp2[EXP_W-1:0], mant2};
            flags_c = {3'b000, inexact2};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= 4'b0000;
        end else if (advance) begin
            out_valid  <= v2;
            out_result <= res_c;
            out_flags  <= flags_c;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe at single precision: directed vectors, backpressure and reset
// sequences, then randomized traffic scored against an arithmetic reference model.
module tb_fp_mult_pipe;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    fp_mult_pipe dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_flags (out_flags)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

`ifdef FP_MULT_PIPE_RNE_EN
    localparam logic [31:0] TIE_RES = 32'h3FC0_0002;
    localparam logic [31:0] OVF_RES = 32'h7F80_0000;
`else
    localparam logic [31:0] TIE_RES = 32'h3FC0_0001;
    localparam logic [31:0] OVF_RES = 32'h7F7F_FFFF;
`endif

    int          checks = 0;
    int          passes = 0;
    int          delivered = 0;
    logic [35:0] sbq[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = '0;
    logic [3:0]  prev_flags = '0;
    vec_t        vecs[10];
    logic [31:0] bp_a[5];
    logic [31:0] bp_b[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact integer product, remainder-based rounding, returns {flags, result}.
    function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem;
`ifdef FP_MULT_PIPE_RNE_EN
        longint unsigned half;
`endif
        logic            s, za, zb, ia, ib, na, nb, sn, inv, inx;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        ma  = 64'(a[22:0]);
        mb  = 64'(b[22:0]);
        s   = a[31] ^ b[31];
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (ma == 0);
        ib  = (eb == 255) && (mb == 0);
        na  = (ea == 255) && (ma != 0);
        nb  = (eb == 255) && (mb != 0);
        sn  = (na && !a[22]) || (nb && !b[22]);
        inv = (ia && zb) || (za && ib);
        if (na || nb || inv) return {inv || sn, 3'b000, 32'h7FC0_0000};
        if (ia || ib) return {4'b0000, s, 31'h7F80_0000};
        if (za || zb) return {4'b0000, s, 31'h0};
        p = (ma + 64'd8388608) * (mb + 64'd8388608);
        e = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end else begin
            sh = 23;
        end
        q   = p >> sh;
        rem = p - (q << sh);
        inx = (rem != 0);
`ifdef FP_MULT_PIPE_RNE_EN
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 31'h7F80_0000};
`else
        if (e >= 255) return {4'b0101, s, 31'h7F7F_FFFF};
`endif
        if (e <= 0) return {4'b0011, s, 31'h0};
        return {3'b000, inx, s, 8'(e), 23'(q)};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] m;
        case ($urandom_range(0, 15))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(1, 40));
            4, 5:    e = 8'($urandom_range(200, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        m = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // One cycle from a negedge: drive, check handshake and outputs, score, advance.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, output logic took);
        logic [35:0] e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !out_valid || ordy);
        if (prev_stall) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_result", out_result, prev_res);
            chk("hold_flags", out_flags, prev_flags);
        end
        if (out_valid && ordy) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else begin
                e = sbq.pop_front();
                chk("stream_result", out_result, e[31:0]);
                chk("stream_flags", out_flags, e[35:32]);
                delivered++;
            end
        end
        prev_stall = out_valid && !ordy;
        prev_res   = out_result;
        prev_flags = out_flags;
        took       = iv && in_ready;
        if (took) sbq.push_back(ref_mul(a, b));
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] flg);
        int edges;
        @(negedge clock);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        @(posedge clock);
        edges = 1;
        @(negedge clock);
        in_valid = 1'b0;
        while (!out_valid && edges < 8) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        chk({name, "_latency"}, edges, 3);
        chk({name, "_result"}, out_result, res);
        chk({name, "_flags"}, out_flags, flg);
        @(posedge clock);
        @(negedge clock);
        chk({name, "_drain"}, out_valid, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1);
    end

    initial begin
        logic        took, pending, first_seen, ordy;
        logic [31:0] ra, rb;
        int          idx, stall_left;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_result", out_result, 32'h0);
        chk("reset_flags", out_flags, 4'b0000);
        #20;
        reset_n = 1'b1;

        vecs[0] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000};
        vecs[1] = '{32'h3F80_0001, 32'h3FC0_0000, TIE_RES,       4'b0001};
        vecs[2] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000};
        vecs[3] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000};
        vecs[4] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b0000};
        vecs[5] = '{32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000};
        vecs[6] = '{32'h7F00_0000, 32'h4000_0000, OVF_RES,       4'b0101};
        vecs[7] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011};
        vecs[8] = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000};
        vecs[9] = '{32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000};
        for (int i = 0; i < 10; i++)
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);

        // Five back-to-back pairs with a four-cycle output stall at the first result.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = {1'b0, 8'(127 + i), 23'(i * 4099 + 7)};
            bp_b[i] = {1'(i & 1), 8'(126 + i), 23'(i * 777 + 3)};
        end
        delivered  = 0;
        idx        = 0;
        first_seen = 1'b0;
        stall_left = 0;
        for (int c = 0; c < 60; c++) begin
            if (idx == 5 && sbq.size() == 0) break;
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 4;
            end
            ordy = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            step(idx < 5, (idx < 5) ? bp_a[idx] : 32'h0, (idx < 5) ? bp_b[idx] : 32'h0, ordy, took);
            if (took) idx++;
        end
        chk("bp_stall_seen", first_seen, 1'b1);
        chk("bp_delivered", delivered, 5);
        chk("bp_pending", sbq.size(), 0);

        // Reset pulse with two pairs in flight, the first already presented.
        step(1'b1, 32'h3FC0_0000, 32'h4000_0000, 1'b1, took);
        step(1'b1, 32'h4040_0000, 32'h3F00_0000, 1'b1, took);
        in_valid = 1'b0;
        @(posedge clock);
        #2;
        chk("rst_pre_valid", out_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_result", out_result, 32'h0);
        chk("rst_async_flags", out_flags, 4'b0000);
        sbq.delete();
        prev_stall = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_hold_valid", out_valid, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b1, took);
            chk("rst_no_stale", out_valid, 1'b0);
        end
        run_one("post_rst", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000, 4'b0000);

        // Randomized traffic with random backpressure; operands held until taken.
        pending = 1'b0;
        ra      = '0;
        rb      = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pending && $urandom_range(0, 9) < 7) begin
                ra      = rand_op();
                rb      = rand_op();
                pending = 1'b1;
            end
            step(pending, ra, rb, $urandom_range(0, 9) < 7, took);
            if (took) pending = 1'b0;
        end
        for (int c = 0; c < 20 && sbq.size() > 0; c++)
            step(1'b0, 32'h0, 32'h0, 1'b1, took);
        chk("rand_drain", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier; next generation of the team's fixed single-precision multiplier.
- Generic exponent/mantissa widths.
- Valid/ready streaming handshake with backpressure.
- Round-to-nearest-even, canonical NaN handling and exception flags.
- Sits between operand-fetch and writeback in the FP datapath; one result per cycle, 3-cycle latency.

Parameters:
EXP_W  8   exponent field width (>=4)
MAN_W  23  stored mantissa field width, hidden bit excluded (>=4)
W = 1+EXP_W+MAN_W (derived localparam); BIAS = 2^(EXP_W-1)-1 (derived)

Ports:
clock       in   1      rising-edge clock
reset_n     in   1      asynchronous, active-low reset
in_valid    in   1      operand pair valid
in_ready    out  1      block accepts operands this cycle
in_a        in   W      operand A {sign, exp, man}
in_b        in   W      operand B
out_valid   out  1      result valid
out_ready   in   1      downstream accepts result
out_result  out  W      product
out_flags   out  4      {invalid, overflow, underflow, inexact}

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, all stage valids, out_valid=0, out_result=0 and out_flags=0, applied immediately. Data in flight is discarded.
- Pipeline control:
  - advance = !out_valid || out_ready; in_ready = advance.
  - Transfer occurs on in_valid && in_ready.
  - All 3 stages shift together on advance, and hold completely (data and valids) when advance=0.
  - Bubbles propagate as valid=0.
  - out_result/out_flags stay stable while out_valid && !out_ready.
- Latency: a result is presented 3 cycles after acceptance when unstalled. Throughput is 1/cycle. Order is preserved.
- Stage 1 (unpack/multiply):
  - Split fields; sign = sa^sb.
  - Classify each operand:
    - zero: exp=0; subnormals are flushed to zero (FTZ).
    - inf: exp=all-ones, man=0.
    - NaN: exp=all-ones, man!=0.
  - Product = {1,manA}*{1,manB}, 2*(MAN_W+1) bits.
  - Exponent sum = ea+eb-BIAS, computed signed in EXP_W+2 bits so it neither wraps nor goes negative unnoticed.
- Stage 2 (normalise/round):
  - If product MSB=1: take the upper MAN_W+1 bits and exp+1. Otherwise shift by one.
  - Guard = next bit; sticky = OR of all remaining bits.
  - RNE: increment when guard && (sticky || lsb).
  - A rounding carry-out renormalises: mantissa=0, exp+1.
  - inexact = guard|sticky.
- Stage 3 (special-case select, priority order):
  1. Any NaN operand, or inf*zero: result = canonical qNaN {0, all-ones, 1 followed by MAN_W-1 zeros}. invalid=1 only for inf*zero or a signalling NaN (man MSB=0). No other flags.
  2. inf*nonzero: signed inf, flags 0.
  3. zero*finite: signed zero, flags 0.
  4. Rounded exp >= 2^EXP_W-1: signed inf, overflow=1, inexact=1.
  5. Rounded exp <= 0: signed zero, underflow=1, inexact=1 (FTZ output).
  6. Otherwise: normal result with the inexact flag from stage 2.
- Flags are per-result, not sticky; they are valid only with out_valid.
- in_valid while in_ready=0: the operands are not captured. The source must hold them until the transfer.

Optional Feature:
FP_MULT_PIPE_RNE_EN
- Defined: round-to-nearest-even as described.
- Undefined: round toward zero (truncate).
  - Guard/sticky still compute inexact.
  - No rounding incrementer and no carry renormalisation.
  - Overflow produces the max finite value {s, all-ones-minus-1, all-ones}, not inf; overflow=1, inexact=1.
- Latency is unchanged in both builds.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2.0), out_ready=1 -> out_valid exactly 3 cycles after accept, result 0x40400000, flags 4'b0000.
- Tie case 0x3F800001 * 0x3FC00000 -> RNE build: 0x3FC00002, flags 4'b0001. Truncate build: 0x3FC00001, flags 4'b0001.
- Specials:
  - 0x7F800000*0x00000000 -> 0x7FC00000, flags 4'b1000.
  - 0xFF800000*0x40000000 -> 0xFF800000, flags 0.
  - 0x7FC00001*0x3F800000 -> 0x7FC00000, flags 0.
  - 0x00400000 (subnormal)*0x3F800000 -> 0x00000000.
- Range: 0x7F000000*0x40000000 -> 0x7F800000, flags 4'b0101 (truncate build: 0x7F7FFFFF). 0x00800000*0x00800000 -> 0x00000000, flags 4'b0011.
- Backpressure: 5 back-to-back operand pairs; out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 while stalled, out_result held stable, all 5 results delivered in order with none lost or duplicated.
- Reset mid-stream: 2 pairs in flight, pulse reset_n low asynchronously mid-cycle -> out_valid=0 immediately. After release, no stale results appear and the first new pair returns correctly in 3 cycles.
